serial_mag_comp_ctrl: RTL

//  Sequenced WIDTH-bit magnitude comparator built around one shared 1-bit compare cell.
//  - On start, latches operands a/b and walks them MSB-first, one bit per clock.
//  - Exits early at the first differing bit; declares equality after the LSB.
//  - Returns a one-hot registered result (yg/yl/ye) with a one-cycle done pulse.
//  - For area-constrained compare paths where latency is acceptable.

---
 rtl/comp_pkg.sv | 15 +
 rtl/bit1_comp.sv | 17 +
 rtl/serial_mag_comp_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and
// result-vector bit positions (also used by the bench).
package comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Bit positions inside the 3-bit one-hot result vector {ye, yl, yg}.
    localparam int unsigned RES_GT = 0;
    localparam int unsigned RES_LT = 1;
    localparam int unsigned RES_EQ = 2;

endpackage

// File: rtl/bit1_comp.sv
// Single-bit magnitude compare cell: exactly one of yg/yl/ye is high.
module bit1_comp (
    input  logic a,
    input  logic b,
    output logic yg,
    output logic yl,
    output logic ye
);

    // Pure combinational compare of one bit pair.
    always_comb begin
        yg = a & ~b;
        yl = ~a & b;
        ye = ~(a ^ b);
    end

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// Sequenced WIDTH-bit magnitude comparator: latches operands on start, walks them
// MSB-first through one shared 1-bit cell, exits at the first differing bit.
module serial_mag_comp_ctrl
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             yg,
    output logic             yl,
    output logic             ye
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [2:0]         r_res;
    logic [2:0]         w_res_nxt;
    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_gt;
    logic               w_lt;
    logic               w_eq;

    // Only the latched copies feed the cell, so live a/b changes never matter.
    assign w_a_bit = r_a[r_idx];
    assign w_b_bit = r_b[r_idx];

    bit1_comp u_bit1_comp (
        .a  (w_a_bit),
        .b  (w_b_bit),
        .yg (w_gt),
        .yl (w_lt),
        .ye (w_eq)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, operand capture, index walk and result update.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_res_nxt   = r_res;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_idx_nxt   = IDX_W'(WIDTH - 1);
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (!w_eq) begin
                    w_res_nxt         = 3'b000;
                    w_res_nxt[RES_GT] = w_gt;
                    w_res_nxt[RES_LT] = w_lt;
                    w_done_nxt        = 1'b1;
                    w_state_nxt       = IDLE;
                end else if (r_idx == '0) begin
                    w_res_nxt         = 3'b000;
                    w_res_nxt[RES_EQ] = 1'b1;
                    w_done_nxt        = 1'b1;
                    w_state_nxt       = IDLE;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath registers: operands, bit index, done pulse and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_res  <= 3'b000;
        end else begin
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_idx  <= w_idx_nxt;
            r_done <= w_done_nxt;
            r_res  <= w_res_nxt;
        end
    end

    assign busy = (r_state == SCAN);
    assign done = r_done;
    assign yg   = r_res[RES_GT];
    assign yl   = r_res[RES_LT];
    assign ye   = r_res[RES_EQ];

endmodule
